// File: rtl/tejuino_pkg.sv
// Shared definitions for the three-stage register/ALU/RAM datapath:
// instruction fields, opcodes, the NOP encoding and issue FSM states.
package tejuino_pkg;

    localparam int unsigned INSTR_W = 17;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    localparam int unsigned OP_MSB  = 16;
    localparam int unsigned OP_LSB  = 15;
    localparam int unsigned RD_MSB  = 14;
    localparam int unsigned RD_LSB  = 10;
    localparam int unsigned RS1_MSB = 9;
    localparam int unsigned RS1_LSB = 5;
    localparam int unsigned RS2_MSB = 4;
    localparam int unsigned RS2_LSB = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 17'h18000;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StRun,
        StDrain,
        StDone
    } issue_state_t;

    typedef struct packed {
        logic       wr;
        logic [4:0] rd;
    } sb_entry_t;

    // Only ALU instructions write back to the register file.
    function automatic logic writes_rd(input logic [1:0] opcode);
        return opcode == OP_ALU;
    endfunction

endpackage

// File: rtl/instr_issue_if.sv
// Bus between the issue unit, its instruction ROM and the run controller.
// master = issue unit side, slave = environment (ROM + controller) side.
interface instr_issue_if #(
    parameter int unsigned ADDR_W = 8
);
    logic                              start;
    logic [ADDR_W:0]                   prog_len;
    logic [ADDR_W-1:0]                 imem_addr;
    logic                              imem_en;
    logic [tejuino_pkg::INSTR_W-1:0]   imem_rdata;
    logic [tejuino_pkg::INSTR_W-1:0]   instr;
    logic                              busy;
    logic                              done;
    logic [15:0]                       stall_count;

    modport master (
        input  start, prog_len, imem_rdata,
        output imem_addr, imem_en, instr, busy, done, stall_count
    );

    modport slave (
        output start, prog_len, imem_rdata,
        input  imem_addr, imem_en, instr, busy, done, stall_count
    );
endinterface

// File: rtl/instr_issue_hazard_scoreboard.sv
// Shift register of recently issued slots plus RAW comparators against the
// candidate's source registers.
module hazard_scoreboard
    import tejuino_pkg::*;
#(
    parameter int unsigned HAZARD_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_shift,
    input  logic       i_wr,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    output logic       o_hazard
);

    sb_entry_t r_sb [HAZARD_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(HAZARD_DEPTH); i++) r_sb[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < int'(HAZARD_DEPTH); i++) r_sb[i] <= '0;
        end else if (i_shift) begin
            r_sb[0] <= '{wr: i_wr, rd: i_rd};
            for (int i = 1; i < int'(HAZARD_DEPTH); i++) r_sb[i] <= r_sb[i-1];
        end
    end

    // Both source fields are compared regardless of opcode (conservative).
    always_comb begin
        o_hazard = 1'b0;
        for (int i = 0; i < int'(HAZARD_DEPTH); i++) begin
            if (r_sb[i].wr && ((r_sb[i].rd == i_rs1) || (r_sb[i].rd == i_rs2))) begin
                o_hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Fetch-and-issue unit: streams a program from a synchronous ROM into the
// datapath, inserting NOP bubbles on RAW hazards and draining at the end.
module instr_issue
    import tejuino_pkg::*;
#(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned HAZARD_DEPTH = 2,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    instr_issue_if.master io_bus
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    issue_state_t          r_state, w_state_next;
    logic [ADDR_W:0]       r_prog_len;
    logic [ADDR_W-1:0]     r_addr;
    logic [ADDR_W-1:0]     r_issue_idx;
    logic [INSTR_W-1:0]    r_instr;
    logic [15:0]           r_stall;
    logic [DW-1:0]         r_drain_cnt;

    logic [INSTR_W-1:0]    w_cand;
    logic                  w_hazard;
    logic                  w_issue;
    logic                  w_last;
    logic                  w_more;

    assign w_cand  = io_bus.imem_rdata;
    assign w_issue = (r_state == StRun) && !w_hazard;
    assign w_last  = ({1'b0, r_issue_idx} == (r_prog_len - 1'b1));
    assign w_more  = ({1'b0, r_addr} < r_prog_len);

    hazard_scoreboard #(
        .HAZARD_DEPTH (HAZARD_DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == StIdle),
        .i_shift  (r_state != StIdle),
        .i_wr     (w_issue && writes_rd(w_cand[OP_MSB:OP_LSB])),
        .i_rd     (w_cand[RD_MSB:RD_LSB]),
        .i_rs1    (w_cand[RS1_MSB:RS1_LSB]),
        .i_rs2    (w_cand[RS2_MSB:RS2_LSB]),
        .o_hazard (w_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= StIdle;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (io_bus.start) w_state_next = (io_bus.prog_len != '0) ? StFetch : StDone;
            end
            StFetch: w_state_next = StRun;
            StRun: begin
                if (w_issue && w_last) w_state_next = StDrain;
            end
            StDrain: begin
                if (r_drain_cnt == DRAIN_LAST) w_state_next = StDone;
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        io_bus.imem_en = (r_state == StFetch) || (w_issue && w_more);
        io_bus.busy    = (r_state == StFetch) || (r_state == StRun) || (r_state == StDrain);
        io_bus.done    = (r_state == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prog_len  <= '0;
            r_addr      <= '0;
            r_issue_idx <= '0;
            r_instr     <= NOP_INSTR;
            r_stall     <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_instr     <= w_issue ? w_cand : NOP_INSTR;
            r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 1'b1 : '0;
            case (r_state)
                StIdle: begin
                    if (io_bus.start) begin
                        r_stall <= '0;
                        if (io_bus.prog_len != '0) begin
                            r_prog_len <= io_bus.prog_len;
                            r_addr     <= '0;
                        end
                    end
                end
                StFetch: begin
                    r_addr      <= ADDR_W'(1);
                    r_issue_idx <= '0;
                end
                StRun: begin
                    // A stall holds the ROM address so the candidate stays put.
                    if (w_hazard) begin
                        if (r_stall != 16'hFFFF) r_stall <= r_stall + 1'b1;
                    end else begin
                        r_issue_idx <= r_issue_idx + 1'b1;
                        if (w_more) r_addr <= r_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.imem_addr   = r_addr;
    assign io_bus.instr       = r_instr;
    assign io_bus.stall_count = r_stall;

endmodule

// File: tb/tb_instr_issue.sv
// Self-checking bench for instr_issue: ROM model, list-based issue model and
// a per-cycle compare process.
module tb_instr_issue;

    localparam int HD    = 2;
    localparam int DRAIN = 2;
    localparam logic [16:0] NOP = 17'h18000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_issue_if #(.ADDR_W(8)) bus ();

    instr_issue #(
        .ADDR_W       (8),
        .HAZARD_DEPTH (HD),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    logic [16:0] prog [256];

    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= prog[bus.imem_addr];

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: the issue stream is the program with bubbles inserted until no
    // writing instruction among the last HD issued slots targets a source.
    logic [16:0] hist[$];
    logic [16:0] trace[$];
    int          trace_idx[$];
    int          bubbles;
    logic [16:0] exp_instr[$];
    logic        exp_en[$];
    logic        exp_busy[$];
    logic        exp_done[$];
    int          exp_stall[$];

    function automatic bit conflict(input logic [16:0] c);
        for (int k = 1; k <= HD; k++) begin
            if (hist.size() >= k) begin
                logic [16:0] e;
                e = hist[hist.size() - k];
                if (e[16:15] == 2'b00 && (e[14:10] == c[9:5] || e[14:10] == c[4:0])) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic build_model(input int n);
        int l;
        int st;
        hist = {}; trace = {}; trace_idx = {}; bubbles = 0;
        exp_instr = {}; exp_en = {}; exp_busy = {}; exp_done = {}; exp_stall = {};
        for (int i = 0; i < n; i++) begin
            while (conflict(prog[i])) begin
                hist.push_back(NOP); trace.push_back(NOP); trace_idx.push_back(-1); bubbles++;
            end
            hist.push_back(prog[i]); trace.push_back(prog[i]); trace_idx.push_back(i);
        end
        if (n == 0) begin
            exp_instr = '{NOP, NOP}; exp_en = '{0, 0}; exp_busy = '{0, 0};
            exp_done = '{1, 0}; exp_stall = '{0, 0};
            return;
        end
        for (int d = 0; d < DRAIN; d++) begin
            trace.push_back(NOP); trace_idx.push_back(-2);
        end
        l = trace.size();
        st = 0;
        for (int c = 0; c <= l + 2; c++) begin
            if (c >= 2 && c - 2 < l && trace_idx[c-2] == -1) st++;
            exp_instr.push_back((c >= 2 && c - 2 < l) ? trace[c-2] : NOP);
            if (c == 0) exp_en.push_back(1'b1);
            else if (c <= l) exp_en.push_back(trace_idx[c-1] >= 0 && trace_idx[c-1] + 1 < n);
            else exp_en.push_back(1'b0);
            exp_busy.push_back(c <= l);
            exp_done.push_back(c == l + 1);
            exp_stall.push_back(st);
        end
    endtask

    int cyc = 0;
    bit chk_active = 0;

    always @(negedge clk) begin
        if (chk_active) begin
            chk($sformatf("instr@c%0d", cyc), 32'(bus.instr), 32'(exp_instr[cyc]));
            chk($sformatf("imem_en@c%0d", cyc), 32'(bus.imem_en), 32'(exp_en[cyc]));
            chk($sformatf("busy@c%0d", cyc), 32'(bus.busy), 32'(exp_busy[cyc]));
            chk($sformatf("done@c%0d", cyc), 32'(bus.done), 32'(exp_done[cyc]));
            chk($sformatf("stall@c%0d", cyc), 32'(bus.stall_count), 32'(exp_stall[cyc]));
            cyc++;
            if (cyc >= exp_instr.size()) chk_active = 0;
        end
    end

    task automatic launch(input int n);
        build_model(n);
        @(negedge clk); #1;
        bus.start = 1'b1; bus.prog_len = 9'(n);
        @(posedge clk); #1;
        bus.start = 1'b0; cyc = 0; chk_active = 1;
    endtask

    task automatic run_prog(input int n, input bit poke);
        launch(n);
        for (int t = 0; t < 600; t++) begin
            @(negedge clk); #2;
            if (poke && t == 2) begin bus.start = 1'b1; bus.prog_len = 9'd5; end
            else bus.start = 1'b0;
            if (!chk_active) break;
        end
        if (chk_active) begin
            chk("run_timeout", 32'(chk_active), 32'(0));
            chk_active = 0;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_instr"}, 32'(bus.instr), 32'(NOP));
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'(0));
        chk({tag, "_en"}, 32'(bus.imem_en), 32'(0));
        chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_done"}, 32'(bus.done), 32'(0));
        chk({tag, "_stall"}, 32'(bus.stall_count), 32'(0));
    endtask

    task automatic rand_prog(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] op;
            op = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            prog[i] = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7))};
        end
    endtask

    logic [16:0] lit[$];

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.prog_len = '0;
        for (int i = 0; i < 256; i++) prog[i] = NOP;
        #12;
        check_reset("reset");
        @(negedge clk); rst = 1'b0;

        // Hazard-free.
        prog[0] = 17'h0C22; prog[1] = 17'h10A2; prog[2] = 17'h1CE1;
        run_prog(3, 0);
        lit = '{17'h0C22, 17'h10A2, 17'h1CE1, NOP, NOP};
        for (int k = 0; k < 5; k++) chk($sformatf("pin_free_%0d", k), 32'(trace[k]), 32'(lit[k]));
        chk("pin_free_stall", 32'(bus.stall_count), 32'(0));

        // Distance-1 RAW on RS1.
        prog[0] = 17'h0C22; prog[1] = 17'h1060;
        run_prog(2, 0);
        lit = '{17'h0C22, NOP, NOP, 17'h1060, NOP, NOP};
        for (int k = 0; k < 6; k++) chk($sformatf("pin_d1_%0d", k), 32'(trace[k]), 32'(lit[k]));
        chk("pin_d1_stall", 32'(bus.stall_count), 32'(2));

        // Distance-2 RAW on RS2.
        prog[0] = 17'h0C22; prog[1] = 17'h1421; prog[2] = 17'h1823;
        run_prog(3, 0);
        lit = '{17'h0C22, 17'h1421, NOP, 17'h1823};
        for (int k = 0; k < 4; k++) chk($sformatf("pin_d2_%0d", k), 32'(trace[k]), 32'(lit[k]));
        chk("pin_d2_stall", 32'(bus.stall_count), 32'(1));

        // Store producer never blocks.
        prog[0] = 17'h8C22; prog[1] = 17'h1060;
        run_prog(2, 0);
        chk("pin_store_bubbles", 32'(bubbles), 32'(0));
        chk("pin_store_stall", 32'(bus.stall_count), 32'(0));

        // Empty program.
        run_prog(0, 0);

        // start while busy is ignored.
        prog[0] = 17'h0C22; prog[1] = 17'h1060; prog[2] = 17'h1421;
        run_prog(3, 1);

        // Reset mid-run, then a clean run.
        prog[0] = 17'h0C22; prog[1] = 17'h1060;
        rand_prog(0);
        launch(8);
        repeat (5) @(negedge clk);
        #2 chk_active = 0; rst = 1'b1;
        #1 check_reset("midrst");
        @(negedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_no_done", 32'(bus.done), 32'(0));
        prog[0] = 17'h0C22; prog[1] = 17'h1060;
        run_prog(2, 0);
        chk("after_rst_stall", 32'(bus.stall_count), 32'(2));

        // Randomized programs.
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 12);
            rand_prog(n);
            run_prog(n, r % 5 == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
